// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: opcode/funct constants,
// ALU operation encoding, class and branch/jump encodings, control bundle.
`default_nettype none

package mips_pkg;

   localparam int XLEN_C = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_NONE = 4'd15
   } alu_op_e;

   localparam logic [1:0] ICLASS_R   = 2'd0;
   localparam logic [1:0] ICLASS_I   = 2'd1;
   localparam logic [1:0] ICLASS_J   = 2'd2;
   localparam logic [1:0] ICLASS_ILL = 2'd3;

   localparam logic [1:0] BR_NONE = 2'd0;
   localparam logic [1:0] BR_EQ   = 2'd1;
   localparam logic [1:0] BR_NE   = 2'd2;

   localparam logic [1:0] JMP_NONE = 2'd0;
   localparam logic [1:0] JMP_DIR  = 2'd1;
   localparam logic [1:0] JMP_REG  = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [1:0] iclass;
      logic [3:0] alu_op;
      logic       use_imm;
      logic       imm_is_zext;
      logic       reg_write;
      logic [4:0] wreg;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] branch;
      logic [1:0] jump;
      logic       ovf_check;
      logic       illegal;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_instr_decoder_if.sv
// Fetch-to-decode request and decoded-instruction result bundle.
`default_nettype none

interface mips_instr_decoder_if;
   logic        in_valid;
   logic [31:0] instr;
   logic        out_valid;
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sh;
   logic [5:0]  fn;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic [25:0] jtarget;
   logic [1:0]  iclass;
   logic [3:0]  alu_op;
   logic        use_imm;
   logic        imm_is_zext;
   logic        reg_write;
   logic [4:0]  wreg;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  branch;
   logic [1:0]  jump;
   logic        ovf_check;
   logic        illegal;

   modport master (
      output in_valid, instr,
      input  out_valid, op, rs, rt, rd, sh, fn, imm_sext, imm_zext, jtarget,
             iclass, alu_op, use_imm, imm_is_zext, reg_write, wreg,
             mem_read, mem_write, branch, jump, ovf_check, illegal
   );

   modport slave (
      input  in_valid, instr,
      output out_valid, op, rs, rt, rd, sh, fn, imm_sext, imm_zext, jtarget,
             iclass, alu_op, use_imm, imm_is_zext, reg_write, wreg,
             mem_read, mem_write, branch, jump, ovf_check, illegal
   );
endinterface

`default_nettype wire

// File: rtl/mips_ctrl_lut.sv
// Combinational op/fn to control-bundle mapping for the decode stage.
`default_nettype none

module mips_ctrl_lut
   import mips_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] fn_i,
   input  logic [4:0] rt_i,
   input  logic [4:0] rd_i,
   output ctrl_t      ctrl_o
);

   ctrl_t c;

   always_comb begin
      c        = '0;
      c.alu_op = ALU_NONE;
      case (op_i)
         OP_RTYPE: begin
            c.iclass    = ICLASS_R;
            c.reg_write = 1'b1;
            c.wreg      = rd_i;
            case (fn_i)
               FN_ADD:  begin c.alu_op = ALU_ADD; c.ovf_check = 1'b1; end
               FN_ADDU: c.alu_op = ALU_ADD;
               FN_SUB:  begin c.alu_op = ALU_SUB; c.ovf_check = 1'b1; end
               FN_SUBU: c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_XOR:  c.alu_op = ALU_XOR;
               FN_NOR:  c.alu_op = ALU_NOR;
               FN_SLT:  c.alu_op = ALU_SLT;
               FN_SLTU: c.alu_op = ALU_SLTU;
               FN_SLL:  c.alu_op = ALU_SLL;
               FN_SRL:  c.alu_op = ALU_SRL;
               FN_SRA:  c.alu_op = ALU_SRA;
               FN_JR:   begin c.jump = JMP_REG; c.reg_write = 1'b0; c.wreg = 5'd0; end
               default: c.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
            c.iclass    = ICLASS_I;
            c.use_imm   = 1'b1;
            c.reg_write = 1'b1;
            c.wreg      = rt_i;
            case (op_i)
               OP_ADDI:  begin c.alu_op = ALU_ADD; c.ovf_check = 1'b1; end
               OP_ADDIU: c.alu_op = ALU_ADD;
               OP_SLTI:  c.alu_op = ALU_SLT;
               OP_SLTIU: c.alu_op = ALU_SLTU;
               OP_ANDI:  begin c.alu_op = ALU_AND; c.imm_is_zext = 1'b1; end
               OP_ORI:   begin c.alu_op = ALU_OR;  c.imm_is_zext = 1'b1; end
               OP_XORI:  begin c.alu_op = ALU_XOR; c.imm_is_zext = 1'b1; end
               OP_LW:    begin c.alu_op = ALU_ADD; c.mem_read = 1'b1; end
               default:  c.alu_op = ALU_LUI;
            endcase
         end
         OP_SW: begin
            c.iclass    = ICLASS_I;
            c.use_imm   = 1'b1;
            c.alu_op    = ALU_ADD;
            c.mem_write = 1'b1;
         end
         OP_BEQ: begin c.iclass = ICLASS_I; c.alu_op = ALU_SUB; c.branch = BR_EQ; end
         OP_BNE: begin c.iclass = ICLASS_I; c.alu_op = ALU_SUB; c.branch = BR_NE; end
         OP_J:   begin c.iclass = ICLASS_J; c.jump = JMP_DIR; end
         OP_JAL: begin
            c.iclass    = ICLASS_J;
            c.jump      = JMP_DIR;
            c.reg_write = 1'b1;
            c.wreg      = 5'd31;
         end
         default: c.illegal = 1'b1;
      endcase

      if (c.illegal) begin
         c         = '0;
         c.iclass  = ICLASS_ILL;
         c.alu_op  = ALU_NONE;
         c.illegal = 1'b1;
      end
      // $0 is hard-wired, so a write to it is dropped here rather than downstream.
      if (c.wreg == 5'd0) c.reg_write = 1'b0;
      ctrl_o = c;
   end

endmodule

`default_nettype wire

// File: rtl/mips_instr_decoder.sv
// Registered MIPS decode stage: captures the instruction word and its
// control bundle on valid; field and immediate outputs are slices of that register.
`default_nettype none

module mips_instr_decoder
   import mips_pkg::*;
#(
   parameter int XLEN = XLEN_C
)(
   input logic                 clk_i,
   input logic                 rst_n_i,
   mips_instr_decoder_if.slave bus
);

   logic [XLEN-1:0] instr_q;
   ctrl_t           ctrl_q;
   ctrl_t           ctrl_d;
   logic            valid_q;

   mips_ctrl_lut u_lut (
      .op_i   (bus.instr[31:26]),
      .fn_i   (bus.instr[5:0]),
      .rt_i   (bus.instr[20:16]),
      .rd_i   (bus.instr[15:11]),
      .ctrl_o (ctrl_d)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            instr_q <= bus.instr;
            ctrl_q  <= ctrl_d;
         end
      end
   end

   // Fields are taken from the held word so they stay stable across invalid cycles.
   assign bus.out_valid   = valid_q;
   assign bus.op          = instr_q[31:26];
   assign bus.rs          = instr_q[25:21];
   assign bus.rt          = instr_q[20:16];
   assign bus.rd          = instr_q[15:11];
   assign bus.sh          = instr_q[10:6];
   assign bus.fn          = instr_q[5:0];
   assign bus.imm_sext    = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
   assign bus.imm_zext    = {{(XLEN-16){1'b0}}, instr_q[15:0]};
   assign bus.jtarget     = instr_q[25:0];
   assign bus.iclass      = ctrl_q.iclass;
   assign bus.alu_op      = ctrl_q.alu_op;
   assign bus.use_imm     = ctrl_q.use_imm;
   assign bus.imm_is_zext = ctrl_q.imm_is_zext;
   assign bus.reg_write   = ctrl_q.reg_write;
   assign bus.wreg        = ctrl_q.wreg;
   assign bus.mem_read    = ctrl_q.mem_read;
   assign bus.mem_write   = ctrl_q.mem_write;
   assign bus.branch      = ctrl_q.branch;
   assign bus.jump        = ctrl_q.jump;
   assign bus.ovf_check   = ctrl_q.ovf_check;
   assign bus.illegal     = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_decoder.sv
// Bench for mips_instr_decoder: directed program steps plus random words,
// each checked against a table-driven instruction-set reference model.
`default_nettype none

module tb_mips_instr_decoder;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [31:0] sext;
      logic [31:0] zext;
      logic [25:0] jt;
      logic [1:0]  iclass;
      logic [3:0]  alu;
      logic        ui;
      logic        zx;
      logic        rw;
      logic [4:0]  wreg;
      logic        mr;
      logic        mw;
      logic [1:0]  br;
      logic [1:0]  jmp;
      logic        ovf;
      logic        ill;
   } dec_t;

   // dest: 0 none, 1 rd, 2 rt, 3 $31
   typedef struct {
      logic [5:0] op;
      int         fn;
      logic [1:0] ic;
      logic [3:0] alu;
      bit         ui;
      bit         zx;
      int         dest;
      bit         mr;
      bit         mw;
      logic [1:0] br;
      logic [1:0] jmp;
      bit         ovf;
   } ent_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   dec_t obs;
   dec_t exp_d;
   logic exp_v;
   ent_t tbl[$];
   logic [31:0] w;
   int   k;

   mips_instr_decoder_if bus ();

   mips_instr_decoder #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {bus.op, bus.rs, bus.rt, bus.rd, bus.sh, bus.fn, bus.imm_sext, bus.imm_zext,
                 bus.jtarget, bus.iclass, bus.alu_op, bus.use_imm, bus.imm_is_zext,
                 bus.reg_write, bus.wreg, bus.mem_read, bus.mem_write, bus.branch,
                 bus.jump, bus.ovf_check, bus.illegal};

   function automatic ent_t E(input logic [5:0] op, input int fn, input logic [1:0] ic,
                              input logic [3:0] alu, input bit ui, input bit zx, input int dest,
                              input bit mr, input bit mw, input logic [1:0] br,
                              input logic [1:0] jmp, input bit ovf);
      ent_t e;
      e.op = op; e.fn = fn; e.ic = ic; e.alu = alu; e.ui = ui; e.zx = zx; e.dest = dest;
      e.mr = mr; e.mw = mw; e.br = br; e.jmp = jmp; e.ovf = ovf;
      return e;
   endfunction

   task automatic build_table();
      //                 op     fn   ic alu ui zx dst mr mw br jmp ovf
      tbl.push_back(E(6'h00, 'h20, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(E(6'h00, 'h21, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h22, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(E(6'h00, 'h23, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h24, 0,  2, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h25, 0,  3, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h26, 0,  4, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h27, 0,  5, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h2A, 0,  6, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h2B, 0,  7, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h00, 0,  8, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h02, 0,  9, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h03, 0, 10, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h00, 'h08, 0, 15, 0, 0, 0, 0, 0, 0, 2, 0));
      tbl.push_back(E(6'h08,   -1, 1,  0, 1, 0, 2, 0, 0, 0, 0, 1));
      tbl.push_back(E(6'h09,   -1, 1,  0, 1, 0, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0A,   -1, 1,  6, 1, 0, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0B,   -1, 1,  7, 1, 0, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0C,   -1, 1,  2, 1, 1, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0D,   -1, 1,  3, 1, 1, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0E,   -1, 1,  4, 1, 1, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h0F,   -1, 1, 11, 1, 0, 2, 0, 0, 0, 0, 0));
      tbl.push_back(E(6'h23,   -1, 1,  0, 1, 0, 2, 1, 0, 0, 0, 0));
      tbl.push_back(E(6'h2B,   -1, 1,  0, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(E(6'h04,   -1, 1,  1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(E(6'h05,   -1, 1,  1, 0, 0, 0, 0, 0, 2, 0, 0));
      tbl.push_back(E(6'h02,   -1, 2, 15, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(E(6'h03,   -1, 2, 15, 0, 0, 3, 0, 0, 0, 1, 0));
   endtask

   function automatic dec_t model(input logic [31:0] iw);
      dec_t d;
      ent_t e;
      bit   hit;
      d    = '0;
      hit  = 0;
      d.op = iw[31:26]; d.rs = iw[25:21]; d.rt = iw[20:16];
      d.rd = iw[15:11]; d.sh = iw[10:6];  d.fn = iw[5:0];
      d.sext = 32'(int'($signed(iw[15:0])));
      d.zext = 32'(iw[15:0]);
      d.jt   = iw[25:0];
      foreach (tbl[i])
         if (tbl[i].op == iw[31:26] && (tbl[i].fn < 0 || tbl[i].fn == int'(iw[5:0]))) begin
            e   = tbl[i];
            hit = 1;
         end
      if (!hit) begin
         d.iclass = 2'd3; d.alu = 4'd15; d.ill = 1'b1;
         return d;
      end
      d.iclass = e.ic; d.alu = e.alu; d.ui = e.ui; d.zx = e.zx;
      d.mr = e.mr; d.mw = e.mw; d.br = e.br; d.jmp = e.jmp; d.ovf = e.ovf;
      case (e.dest)
         1:       d.wreg = iw[15:11];
         2:       d.wreg = iw[20:16];
         3:       d.wreg = 5'd31;
         default: d.wreg = 5'd0;
      endcase
      d.rw = (e.dest != 0) && (d.wreg != 5'd0);
      return d;
   endfunction

   task automatic chk(input string tag, input logic [143:0] o, input logic [143:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] iw);
      @(negedge clk);
      bus.in_valid = v;
      bus.instr    = iw;
      @(posedge clk);
      #1;
      if (v) exp_d = model(iw);
      exp_v = v;
      chk("out_valid", 144'(bus.out_valid), 144'(exp_v));
      chk("decode", 144'(obs), 144'(exp_d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      exp_d        = '0;
      exp_v        = 1'b0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.instr    = '0;
      build_table();

      #3;
      chk("reset_valid", 144'(bus.out_valid), 144'(0));
      chk("reset_outputs", 144'(obs), 144'(0));
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 32'h20010005);
      chk("addi_ctl", 144'({bus.op, bus.rs, bus.rt, bus.imm_sext, bus.alu_op, bus.use_imm,
                            bus.ovf_check, bus.wreg, bus.reg_write}),
                      144'({6'h08, 5'd0, 5'd1, 32'd5, 4'd0, 1'b1, 1'b1, 5'd1, 1'b1}));
      step(1'b1, 32'h00221820);
      chk("add_ctl", 144'({bus.iclass, bus.rd, bus.fn, bus.wreg, bus.reg_write}),
                     144'({2'd0, 5'd3, 6'h20, 5'd3, 1'b1}));
      step(1'b1, 32'h00000000);
      chk("sll0_rw", 144'({bus.out_valid, bus.reg_write, bus.wreg}), 144'({1'b1, 1'b0, 5'd0}));
      step(1'b1, 32'h8C22FFFC);
      chk("lw_ctl", 144'({bus.imm_sext, bus.imm_zext, bus.mem_read, bus.wreg}),
                    144'({32'hFFFFFFFC, 32'h0000FFFC, 1'b1, 5'd2}));
      step(1'b1, 32'h3422FFFF);
      chk("ori_zx", 144'(bus.imm_is_zext), 144'(1));
      step(1'b1, 32'h0C000010);
      chk("jal_ctl", 144'({bus.jump, bus.jtarget, bus.wreg, bus.reg_write}),
                     144'({2'd1, 26'h0000010, 5'd31, 1'b1}));
      step(1'b1, 32'h03E00008);
      chk("jr_ctl", 144'({bus.jump, bus.reg_write}), 144'({2'd2, 1'b0}));
      step(1'b1, 32'hFC000000);
      chk("ill_op", 144'({bus.illegal, bus.iclass, bus.alu_op, bus.reg_write, bus.wreg}),
                    144'({1'b1, 2'd3, 4'd15, 1'b0, 5'd0}));
      step(1'b1, 32'h0000003F);
      chk("ill_fn", 144'({bus.illegal, bus.iclass}), 144'({1'b1, 2'd3}));
      step(1'b1, 32'h00A41022);
      step(1'b0, 32'h12345678);
      chk("gap_hold", 144'({bus.out_valid, bus.op, bus.rd, bus.fn}),
                      144'({1'b0, 6'h00, 5'd2, 6'h22}));

      // Reset asserted mid-cycle with a valid word pending.
      step(1'b1, 32'h2D2AFFFF);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.instr    = 32'h8C22FFFC;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 144'(bus.out_valid), 144'(0));
      chk("async_rst_outputs", 144'(obs), 144'(0));
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      @(posedge clk);
      #1;
      exp_d = '0;
      exp_v = 1'b0;
      chk("post_rst_valid", 144'(bus.out_valid), 144'(0));
      chk("post_rst_outputs", 144'(obs), 144'(0));

      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            k = $urandom_range(0, tbl.size() - 1);
            w[31:26] = tbl[k].op;
            if (tbl[k].fn >= 0) w[5:0] = 6'(tbl[k].fn);
         end
         if ($urandom_range(0, 7) == 0) begin
            w[15:11] = 5'd0;
            w[20:16] = 5'd0;
         end
         step($urandom_range(0, 4) != 0, w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mips_instr_decoder.md
Name: mips_instr_decoder

Overview:
- Registered decode stage for the 32-bit MIPS general-purpose processor.
- Splits a fetched instruction word into its fields (op, rs, rt, rd, sh, fn, immediate, jump target).
- Derives the control signals consumed by the execute and store stages.
- One-cycle latency, valid-qualified. Sits between instruction fetch and register read/execute.

Parameters:
- XLEN, 32, instruction and data word width; fixed at 32.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- In_valid  in  1  Instr is valid this cycle.
- Instr  in  32  instruction word.
- Out_valid  out  1  registered outputs hold a decoded instruction.
- Op  out  6  Instr[31:26].
- Rs  out  5  Instr[25:21].
- Rt  out  5  Instr[20:16].
- Rd  out  5  Instr[15:11].
- Sh  out  5  Instr[10:6].
- Fn  out  6  Instr[5:0].
- ImmSext  out  32  Instr[15:0] sign-extended.
- ImmZext  out  32  Instr[15:0] zero-extended.
- JTarget  out  26  Instr[25:0].
- IClass  out  2  0 = R-type, 1 = I-type, 2 = J-type, 3 = illegal.
- AluOp  out  4  ALU operation code (package encoding).
- UseImm  out  1  ALU B operand is the immediate.
- ImmIsZext  out  1  select ImmZext, else ImmSext.
- RegWrite  out  1  write-back enable.
- WReg  out  5  destination register.
- MemRead  out  1  load.
- MemWrite  out  1  store.
- Branch  out  2  0 = none, 1 = beq, 2 = bne.
- Jump  out  2  0 = none, 1 = j/jal, 2 = jr.
- OvfCheck  out  1  signed-overflow trap applies (add, sub, addi).
- Illegal  out  1  unsupported encoding.

Behaviour:
- Reset (Rst=0, asynchronous): every output is 0, including Out_valid. Reset is released synchronously to Clk.
- Latency: an instruction sampled at a Clk rising edge with In_valid=1 appears on all outputs after that edge, with Out_valid=1.
- In_valid=0 at an edge: Out_valid goes to 0 and all other outputs hold their previous values.
- Back-to-back valid inputs: one decoded instruction per cycle, no bubbles, no backpressure.
- Field outputs are raw slices and are always loaded on valid, regardless of opcode legality.

R-type (Op=0x00), selected by Fn:
- 0x20 add: ADD, OvfCheck=1.
- 0x21 addu: ADD.
- 0x22 sub: SUB, OvfCheck=1.
- 0x23 subu: SUB.
- 0x24 and: AND. 0x25 or: OR. 0x26 xor: XOR. 0x27 nor: NOR.
- 0x2A slt: SLT. 0x2B sltu: SLTU.
- 0x00 sll: SLL. 0x02 srl: SRL. 0x03 sra: SRA. Shift amount comes from Sh.
- 0x08 jr: Jump=2, RegWrite=0.
- Any other Fn: illegal.
- R-type destination: WReg=Rd.

I-type:
- 0x08 addi: ADD, sign-extended immediate, OvfCheck=1.
- 0x09 addiu: ADD, sign-extended.
- 0x0A slti: SLT, sign-extended. 0x0B sltiu: SLTU, sign-extended.
- 0x0C andi: AND, ImmIsZext=1. 0x0D ori: OR, ImmIsZext=1. 0x0E xori: XOR, ImmIsZext=1.
- 0x0F lui: LUI.
- 0x23 lw: ADD, MemRead=1.
- 0x2B sw: ADD, MemWrite=1, RegWrite=0.
- 0x04 beq: SUB, Branch=1, RegWrite=0. 0x05 bne: SUB, Branch=2, RegWrite=0.
- All I-type set UseImm=1 except beq and bne.
- I-type destination: WReg=Rt.

J-type:
- 0x02 j: Jump=1, RegWrite=0.
- 0x03 jal: Jump=1, WReg=31, RegWrite=1.

Illegal and write-back rules:
- Any other Op, or an unknown R-type Fn: IClass=3, Illegal=1.
- Illegal instructions force all control outputs to 0 and AluOp=NONE.
- RegWrite is forced to 0 whenever WReg=0, since $0 is read-only.
- Instructions with no destination set WReg=0.

Decomposition:
- Shared package mips_pkg: opcode constants, funct constants, IClass encoding, Branch/Jump encodings.
- mips_pkg also holds AluOp encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, NONE=15.
- One sub-module, mips_ctrl_lut: purely combinational op/fn to control mapping. The top level adds field slicing, extension and output registers.

Test Plan:
- Reset: drive Rst=0 mid-stream with In_valid=1 -> all outputs 0 immediately. First edge after release with In_valid=0 -> Out_valid stays 0.
- 0x20010005 (addi $1,$0,5) -> Op=0x08, Rs=0, Rt=1, ImmSext=5, AluOp=ADD, UseImm=1, OvfCheck=1, WReg=1, RegWrite=1, Out_valid=1 one cycle later.
- 0x00221820 (add $3,$1,$2) -> IClass=0, Rd=3, Fn=0x20, WReg=3, RegWrite=1. Follow with 0x00000000 (sll $0) -> RegWrite=0, one result per cycle.
- 0x8C22FFFC (lw $2,-4($1)) -> ImmSext=0xFFFFFFFC, ImmZext=0x0000FFFC, MemRead=1, WReg=2. Then 0x3422FFFF (ori) -> ImmIsZext=1.
- 0x0C000010 (jal) -> Jump=1, JTarget=0x0000010, WReg=31, RegWrite=1. Then 0x03E00008 (jr $31) -> Jump=2, RegWrite=0.
- 0xFC000000 and 0x0000003F -> Illegal=1, IClass=3, all controls 0. An In_valid=0 gap -> Out_valid=0 and fields hold.
